// File: rtl/pat_step_ctrl.sv
// pat_step_ctrl: button-driven run/pause/step/direction controller producing a single-cycle pattern-advance strobe
module pat_step_ctrl #(
    parameter int DIV_N = 25,
    parameter int DEB_N = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_run_n,
    input  logic btn_step_n,
    input  logic btn_dir_n,
    output logic adv,
    output logic dir,
    output logic running
);
    typedef enum logic {RUN = 1'b0, PAUSE = 1'b1} state_t;

    logic [2:0]       btn;
    logic [2:0]       sync1;
    logic [2:0]       sync2;
    logic [2:0]       press;
    logic             run_press;
    logic             step_press;
    logic             dir_press;
    logic             tick;
    logic             adv_nx;
    logic [DIV_N-1:0] pre;
    state_t           state;
    state_t           state_nx;

    assign btn        = {btn_dir_n, btn_step_n, btn_run_n};
    assign run_press  = press[0];
    assign step_press = press[1];
    assign dir_press  = press[2];
    assign tick       = &pre;

    // two-flop synchronizers; reset to the released level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    genvar i;
    generate
        for (i = 0; i < 3; i++) begin : g_deb
            logic             stable;
            logic [DEB_N-1:0] cnt;
            logic             prs;
            // accept a new level after 2^DEB_N agreeing samples; pulse on an accepted press only
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stable <= 1'b1;
                    cnt    <= '0;
                    prs    <= 1'b0;
                end else begin
                    prs <= 1'b0;
                    if (sync2[i] == stable) begin
                        cnt <= '0;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        stable <= sync2[i];
                        cnt    <= '0;
                        prs    <= stable;
                    end
                end
            end
            assign press[i] = prs;
        end
    endgenerate

    // next state and next strobe: a run press toggles state and suppresses any strobe that cycle
    always_comb begin
        state_nx = run_press ? ((state == RUN) ? PAUSE : RUN) : state;
        adv_nx   = !run_press && ((state == RUN) ? tick : step_press);
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nx;
    end

    // prescaler: counts while running, holds on pause, restarts from zero on resume
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         pre <= '0;
        else if (state == PAUSE && run_press) pre <= '0;
        else if (state == RUN && !run_press)  pre <= pre + 1'b1;
    end

    // registered outputs; dir toggles on the same edge as a coincident strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adv     <= 1'b0;
            dir     <= 1'b0;
            running <= 1'b1;
        end else begin
            adv     <= adv_nx;
            dir     <= dir ^ dir_press;
            running <= (state_nx == RUN);
        end
    end
endmodule

// File: doc/pat_step_ctrl.md
# pat_step_ctrl

Pattern-advance controller placed directly upstream of the 14-segment pattern sequencer. It replaces the free-running divided-clock strobe with a controlled single-cycle `adv` pulse. Three active-low board pushbuttons drive it: run/pause, single-step and direction. It also outputs a direction flag, so the downstream pattern counter can step forward or backward.

## Interface
- `DIV_N`, 25: prescaler width. In RUN, `adv` period is 2^DIV_N cycles.
- `DEB_N`, 20: debounce counter width. A button must hold a new level for 2^DEB_N consecutive synchronized samples before it is accepted.
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `btn_run_n`  in  1  run/pause toggle button, asynchronous, active-low (0 = pressed).
- `btn_step_n`  in  1  single-step button, asynchronous, active-low.
- `btn_dir_n`  in  1  direction toggle button, asynchronous, active-low.
- `adv`  out  1  one-cycle pattern-advance strobe, registered.
- `dir`  out  1  0 = forward, 1 = reverse, registered.
- `running`  out  1  1 when the FSM is in RUN, registered.

## Operation
- **Synchronizer.** Each button passes through a 2-flop synchronizer. Both flops reset to 1 (released).
- **Debouncer.** Each button has its own debouncer: `stable` (resets to 1) and a DEB_N-bit `cnt` (resets to 0).
  - If the synchronized value equals `stable`: `cnt` <= 0.
  - If it differs and `cnt` < 2^DEB_N-1: `cnt` <= `cnt`+1.
  - If it differs and `cnt` == 2^DEB_N-1: `stable` flips and `cnt` <= 0.
  - A glitch shorter than 2^DEB_N samples resets the count and is never accepted.
- **Press event.** A one-cycle internal pulse, registered on the same edge at which `stable` goes 1->0. Releases (0->1) produce no event.
- **Prescaler.** A DIV_N-bit `pre` counter resets to 0. It increments every cycle in RUN and holds in PAUSE. `tick` = (`pre` == all-ones); `pre` wraps to 0.
- **FSM.** Two states, RUN and PAUSE; reset state is RUN.
  - RUN + run press -> PAUSE. `pre` holds its value.
  - PAUSE + run press -> RUN. `pre` <= 0, so the first tick after resuming comes a full period later.
- **`adv` generation.**
  - In RUN: `adv` <= `tick`. Step presses are ignored.
  - In PAUSE: `adv` <= step press.
- **Simultaneous events.**
  - Run press and `tick` in the same RUN cycle: the state change wins, and `adv` stays 0 for that tick.
  - Run press and step press in the same PAUSE cycle: go to RUN; the step is dropped.
- **Direction.** `dir` toggles on each dir press, in any state. When a dir press and an `adv` strobe land on the same edge, the `adv` cycle already shows the new `dir`.
- **`running`.** Equals (state == RUN), registered.
- **Reset mid-operation.** Asserting `rst_n` low clears all synchronizers, debouncers, `pre`, the state and all outputs immediately, with no clock required. A button held through reset release must complete a full debounce before it registers.

## Timing
- **Reset values:** `adv` = 0, `dir` = 0, `running` = 1, `pre` = 0, every `stable` = 1, every `cnt` = 0.
- **First `adv` after reset release.** Counting the first rising edge after release as edge 1, `adv` is high for the single cycle after edge 2^DIV_N. After that, `adv` is high one cycle in every 2^DIV_N.
- **Button latency.** Take a clean press that starts before edge 1; edge 1 is the first edge to sample the low level.
  - The synchronized value is low after edge 2.
  - `stable` flips, and the press event fires, at edge 2^DEB_N+2.
  - `adv` (in PAUSE), `dir` or `running` change at edge 2^DEB_N+3.
- **Pulse shape.** `adv` is never high for two consecutive cycles. Exactly one press event is produced per accepted press, no matter how long the button is held.

## Test plan
Use DIV_N=4 and DEB_N=4 throughout.

- **Reset and free run.** Release reset with no buttons pressed -> `running`=1, `dir`=0; `adv` high for exactly one cycle after edges 16, 32 and 48, and low at all other times.
- **Pause and step.** Hold `btn_run_n` low for 30 cycles -> `running` falls 19 edges after the first low sample, and no further `adv` occurs.
  - Then press `btn_step_n` twice -> exactly two single-cycle `adv` pulses, each 19 edges after its press.
- **Resume alignment.** From PAUSE, press run -> `running`=1 at the press edge (call it E) and `pre` cleared; the next `adv` comes after edge E+16.
- **Bounce rejection.** Toggle `btn_dir_n` low for 10 cycles, high for 2, then low for 25 -> `dir` changes only once, 19 edges after the start of the final low run.
  - A step press while in RUN -> no extra `adv`.
- **Collisions.** Align the run-press acceptance with the edge where `pre` = 15 -> `adv` stays 0 and `running`=0.
  - In PAUSE, accept run and step presses on the same edge -> `running`=1 and no `adv`.
- **Async reset.** Assert `rst_n` between clock edges while `pre`=9, `dir`=1 and the FSM is in PAUSE -> all outputs take their reset values immediately.
  - After release, the first `adv` comes after edge 16.
